shaper_req_queue: RTL



---
 rtl/shaper_req_queue.sv | 80 ++++++++
 1 files changed

// File: rtl/shaper_req_queue.sv
// Ingress request FIFO in front of token_bucket: stores descriptors, requests
// the bucket for the head entry and emits each granted descriptor as a pulse.
module shaper_req_queue #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              req_o,
    input  logic              grant_i,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [AW:0]       count_o,
    input  logic              flush_i,
    output logic              err_o
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic [AW:0]       count_q;
    logic              req_q;
    logic              full;
    logic              push;
    logic              pop;

    assign full       = (count_q == (AW+1)'(DEPTH));
    assign in_ready_o = !full && !flush_i;
    // A grant this cycle retires the head, so keep requesting only if a second entry exists.
    assign req_o      = !flush_i && (count_q > {{AW{1'b0}}, grant_i});
    assign push       = in_valid_i && in_ready_o;
    assign pop        = grant_i && req_q;
    assign count_o    = count_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count_q     <= '0;
            req_q       <= 1'b0;
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            err_o       <= 1'b0;
        end else begin
            req_q       <= req_o;
            out_valid_o <= pop;
            if (pop) begin
                out_data_o <= mem[rd_ptr];
            end
            if (grant_i && !req_q) begin
                err_o <= 1'b1;
            end
            // Flush still emits a concurrently granted head; push is already blocked.
            if (flush_i) begin
                count_q <= '0;
                rd_ptr  <= wr_ptr;
                req_q   <= 1'b0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
            end
        end
    end

endmodule
